// File: rtl/ext_int_ctrl_pkg.sv
// Shared definitions for the machine external interrupt controller:
// FSM state encoding and the mcause value the trap side reports.
package ext_int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000000b;

endpackage

// File: rtl/ext_int_ctrl_prio_enc.sv
// Combinational lowest-index-wins priority encoder; o_vld flags any request.
// Zero latency, no flow control.
module ext_int_ctrl_prio_enc
  import ext_int_ctrl_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] i_req,
  output logic             o_vld,
  output logic [ID_W-1:0]  o_id
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    o_vld = 1'b0;
    o_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_vld = 1'b1;
        o_id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/ext_int_ctrl.sv
// Machine external interrupt controller: pending latch, fixed priority, REQ/SERVICE handshake with int_ack/ret.
// int_req rises one edge after pending sets (plus 2 edges with EXT_INT_SYNC_EN); the next request waits for ret.
module ext_int_ctrl
  import ext_int_ctrl_pkg::*;
#(
  parameter int               N_SRC     = 8,
  parameter int               ID_W      = 3,
  parameter logic [N_SRC-1:0] EDGE_MASK = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_en,
  input  logic             int_ack,
  input  logic             ret,
  output logic             int_req,
  output logic [ID_W-1:0]  irq_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  state_t             r_state;
  logic               r_int_req;
  logic               r_busy;
  logic [ID_W-1:0]    r_irq_id;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_prev;

  logic [N_SRC-1:0]   w_src;
  logic [N_SRC-1:0]   w_cand;
  logic [N_SRC-1:0]   w_cand_sh;
  logic [N_SRC-1:0]   w_rise;
  logic [N_SRC-1:0]   w_clr;
  logic               w_cur;
  logic               w_ack;
  logic               w_vld;
  logic [ID_W-1:0]    w_win;

`ifdef EXT_INT_SYNC_EN
  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  assign w_cand    = r_pending & irq_en;
  assign w_cand_sh = w_cand >> r_irq_id;
  assign w_cur     = w_cand_sh[0];
  assign w_ack     = (r_state == REQ) && int_ack;
  assign w_clr     = (w_ack ? (N_SRC'(1) << r_irq_id) : '0) & EDGE_MASK;
  assign w_rise    = w_src & ~r_prev;

  ext_int_ctrl_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .i_req (w_cand),
    .o_vld (w_vld),
    .o_id  (w_win)
  );

  // Edge bits OR in the new rise after the ack clear, so a fresh edge survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_prev    <= '0;
    end else begin
      r_pending <= (EDGE_MASK & ((r_pending & ~w_clr) | w_rise)) | (~EDGE_MASK & w_src);
      r_prev    <= w_src;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_int_req <= 1'b0;
      r_busy    <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_vld) begin
            r_irq_id  <= w_win;
            r_int_req <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            r_int_req <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SERVICE;
          end else if (!w_cur) begin
            r_int_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        SERVICE: begin
          if (ret) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_int_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign int_req = r_int_req;
  assign irq_id  = r_irq_id;
  assign busy    = r_busy;
  assign pending = r_pending;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Bench for ext_int_ctrl: directed test-plan sequences plus random traffic,
// scored cycle by cycle against a behavioural model through an expectation queue.
module tb_ext_int_ctrl;

  localparam logic [7:0] EDGE = 8'h20;
`ifdef EXT_INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    bit       req;
    int       id;
    bit       busy;
    bit [7:0] pend;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic [7:0] irq_src;
  logic [7:0] irq_en;
  logic       int_ack;
  logic       ret;
  logic       int_req;
  logic [2:0] irq_id;
  logic       busy;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model state: mode 0 idle, 1 requesting, 2 in service.
  int       m_mode;
  int       m_id;
  bit       m_req;
  bit       m_busy;
  bit [7:0] m_pend;
  bit [7:0] m_prev;
  bit [7:0] m_sy1;
  bit [7:0] m_sy2;

  ext_int_ctrl #(
    .N_SRC     (8),
    .ID_W      (3),
    .EDGE_MASK (EDGE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .irq_src (irq_src),
    .irq_en  (irq_en),
    .int_ack (int_ack),
    .ret     (ret),
    .int_req (int_req),
    .irq_id  (irq_id),
    .busy    (busy),
    .pending (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lowest(bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_id = 0; m_req = 0; m_busy = 0;
    m_pend = '0; m_prev = '0; m_sy1 = '0; m_sy2 = '0;
  endtask

  task automatic model_step(bit [7:0] src, bit [7:0] en, bit ack, bit rt);
    bit [7:0] s, cand, clr, nxt;
    exp_t e;
    s    = (LAT != 0) ? m_sy2 : src;
    cand = m_pend & en;
    clr  = '0;
    if (m_mode == 0) begin
      if (cand != 0) begin
        m_id = lowest(cand); m_req = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        m_req = 0; m_busy = 1; m_mode = 2;
        clr[m_id] = EDGE[m_id];
      end else if (!cand[m_id]) begin
        m_req = 0; m_mode = 0;
      end
    end else if (rt) begin
      m_busy = 0; m_mode = 0;
    end
    for (int i = 0; i < 8; i++)
      nxt[i] = EDGE[i] ? ((m_pend[i] & ~clr[i]) | (s[i] & ~m_prev[i])) : s[i];
    m_pend = nxt;
    m_prev = s;
    m_sy2  = m_sy1;
    m_sy1  = src;
    e.req = m_req; e.id = m_id; e.busy = m_busy; e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive on the falling edge, record expectation, return just after the rising edge.
  task automatic cyc(bit [7:0] src, bit [7:0] en, bit ack, bit rt);
    @(negedge clock);
    irq_src = src; irq_en = en; int_ack = ack; ret = rt;
    model_step(src, en, ack, rt);
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    irq_src = '0; int_ack = 0; ret = 0;
    #1;
    chk("rst_int_req", int_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_irq_id", irq_id, 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  always begin
    @(posedge clock);
    #1;
    if (reset_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int_req !== e.req || (e.req && irq_id !== 3'(e.id)) || busy !== e.busy ||
          pending !== e.pend || ((e.req || e.busy) && irq_id !== 3'(e.id))) begin
        errors++;
        $display("FAIL scoreboard: got req=%0b id=%0d busy=%0b pend=%02h, expected req=%0b id=%0d busy=%0b pend=%02h at %0t",
                 int_req, irq_id, busy, pending, e.req, e.id, e.busy, e.pend, $time);
      end
    end
  end

  initial begin
    reset_n = 1'b0; irq_src = '0; irq_en = '0; int_ack = 0; ret = 0;
    model_reset();
    #1;
    chk("por_int_req", int_req, 0);
    chk("por_pending", pending, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Level source 3: request, ack, ret, re-request while still high.
    cyc(8'h08, 8'hFF, 0, 0);
    repeat (LAT) cyc(8'h08, 8'hFF, 0, 0);
    chk("t1_pend", pending, 8'h08);
    chk("t1_req_early", int_req, 0);
    cyc(8'h08, 8'hFF, 0, 0);
    chk("t1_req", int_req, 1);
    chk("t1_id", irq_id, 3);
    cyc(8'h08, 8'hFF, 1, 0);
    chk("t1_ack_req", int_req, 0);
    chk("t1_ack_busy", busy, 1);
    cyc(8'h08, 8'hFF, 0, 1);
    chk("t1_ret_busy", busy, 0);
    cyc(8'h08, 8'hFF, 0, 0);
    chk("t1_rereq", int_req, 1);
    chk("t1_rereq_id", irq_id, 3);
    cyc(8'h00, 8'hFF, 1, 0);
    repeat (LAT + 1) cyc(8'h00, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 1);
    cyc(8'h00, 8'hFF, 0, 0);

    // Edge source 5: pulse, ack clears, second pulse during service.
    cyc(8'h20, 8'hFF, 0, 0);
    repeat (LAT) cyc(8'h00, 8'hFF, 0, 0);
    chk("t2_pend", pending, 8'h20);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t2_req", int_req, 1);
    chk("t2_id", irq_id, 5);
    cyc(8'h00, 8'hFF, 1, 0);
    chk("t2_ack_pend", pending, 8'h00);
    cyc(8'h20, 8'hFF, 0, 0);
    repeat (LAT) cyc(8'h00, 8'hFF, 0, 0);
    chk("t2_pend2", pending, 8'h20);
    cyc(8'h00, 8'hFF, 0, 1);
    chk("t2_ret_req", int_req, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t2_rereq", int_req, 1);
    chk("t2_rereq_id", irq_id, 5);
    cyc(8'h00, 8'hFF, 1, 0);
    cyc(8'h00, 8'hFF, 0, 1);

    // Sources 2 and 6 together: 2 first, then 6.
    cyc(8'h44, 8'hFF, 0, 0);
    repeat (LAT) cyc(8'h44, 8'hFF, 0, 0);
    cyc(8'h44, 8'hFF, 0, 0);
    chk("t3_id_first", irq_id, 2);
    cyc(8'h40, 8'hFF, 1, 0);
    repeat (LAT + 1) cyc(8'h40, 8'hFF, 0, 0);
    cyc(8'h40, 8'hFF, 0, 1);
    cyc(8'h40, 8'hFF, 0, 0);
    chk("t3_req_second", int_req, 1);
    chk("t3_id_second", irq_id, 6);
    cyc(8'h00, 8'hFF, 1, 0);
    repeat (LAT + 1) cyc(8'h00, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 1);

    // Source 4 withdrawn by clearing its enable; then ack racing the clear.
    cyc(8'h10, 8'hFF, 0, 0);
    repeat (LAT) cyc(8'h10, 8'hFF, 0, 0);
    cyc(8'h10, 8'hFF, 0, 0);
    chk("t4_id", irq_id, 4);
    cyc(8'h10, 8'hEF, 0, 0);
    chk("t4_withdraw", int_req, 0);
    cyc(8'h10, 8'hFF, 0, 0);
    chk("t4_rereq", int_req, 1);
    cyc(8'h10, 8'hEF, 1, 0);
    chk("t4_ack_wins", busy, 1);
    cyc(8'h00, 8'hFF, 0, 1);
    repeat (LAT + 1) cyc(8'h00, 8'hFF, 0, 0);

    // Reset in SERVICE with pending 0x81.
    cyc(8'h81, 8'hFF, 0, 0);
    repeat (LAT) cyc(8'h81, 8'hFF, 0, 0);
    cyc(8'h81, 8'hFF, 0, 0);
    cyc(8'h81, 8'hFF, 1, 0);
    chk("t5_pend", pending, 8'h81);
    chk("t5_busy", busy, 1);
    do_reset();
    repeat (3) cyc(8'h00, 8'hFF, 0, 0);
    chk("t5_quiet", int_req, 0);

    // Request latency for level source 0.
    cyc(8'h01, 8'hFF, 0, 0);
    repeat (LAT) cyc(8'h01, 8'hFF, 0, 0);
    chk("t6_req_pre", int_req, 0);
    cyc(8'h01, 8'hFF, 0, 0);
    chk("t6_req", int_req, 1);
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bit [7:0] s, en;
      s  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      cyc(s, en, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      if (n == 700) do_reset();
    end
    cyc(8'h00, 8'hFF, 0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
